rf_wb_arbiter: RTL and testbench

Write-port controller for the integer register file (`ysyx_22040000_RegisterFile`). It shares the file's single write port among `NREQ` writeback requesters (EXU result, LSU load data) with round-robin arbitration and registers the winning write into `wen`/`waddr`/`wdata`. It also keeps a per-register busy scoreboard. The decoder allocates destinations through a handshake and queries the busy bits for RAW/WAW stalls.

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_wb_arbiter_rr.sv | 44 ++++
 rtl/rf_wb_arbiter.sv | 108 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the integer register-file writeback port controller.
package ysyx_22040000_rf_pkg;

   localparam int AWIDTH_DEF = 5;
   localparam int DWIDTH_DEF = 32;

   localparam int REQ_EXU = 0;
   localparam int REQ_LSU = 1;

   typedef struct packed {
      logic [AWIDTH_DEF-1:0] addr;
      logic [DWIDTH_DEF-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin grant among writeback requesters; owns the rotating pointer.
module ysyx_22040000_RrArbiter
   import ysyx_22040000_rf_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant
);

   localparam int RW = $clog2(NREQ);

   logic [RW-1:0] rr_q;
   logic [RW-1:0] rr_d;
   logic          found;

   // Outer loop walks priority order starting at rr; first hit wins.
   always_comb begin
      grant = '0;
      rr_d  = rr_q;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && rst_n && req[i] &&
                i == (int'(rr_q) + k) % NREQ) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               rr_d     = RW'((i + 1) % NREQ);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: arbitrated registered write stage
// plus a per-register busy scoreboard for decoder stalls.
module rf_wb_arbiter
   import ysyx_22040000_rf_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_DEF,
   parameter int DWIDTH = DWIDTH_DEF,
   parameter int NREQ   = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NREQ-1:0]             wb_valid,
   output logic [NREQ-1:0]             wb_ready,
   input  logic [NREQ-1:0][AWIDTH-1:0] wb_addr,
   input  logic [NREQ-1:0][DWIDTH-1:0] wb_data,
   output logic                        rf_wen,
   output logic [AWIDTH-1:0]           rf_waddr,
   output logic [DWIDTH-1:0]           rf_wdata,
   input  logic                        alloc_valid,
   input  logic [AWIDTH-1:0]           alloc_rd,
   output logic                        alloc_ready,
   input  logic [AWIDTH-1:0]           rs1_addr,
   input  logic [AWIDTH-1:0]           rs2_addr,
   output logic                        rs1_busy,
   output logic                        rs2_busy
);

   localparam int NREG = 2**AWIDTH;

   logic [NREQ-1:0]   grant;
   logic              acc;
   logic [AWIDTH-1:0] sel_addr;
   logic [DWIDTH-1:0] sel_data;
   logic              alloc_fire;

   logic              rf_wen_q, rf_wen_d;
   logic [AWIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DWIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic [NREG-1:0]   busy_q, busy_d;

   ysyx_22040000_RrArbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (wb_valid),
      .grant (grant)
   );

   assign wb_ready = grant;
   assign acc      = |grant;

   // Grant is one-hot, so an AND-OR mux picks the winner.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         sel_addr = sel_addr | ({AWIDTH{grant[i]}} & wb_addr[i]);
         sel_data = sel_data | ({DWIDTH{grant[i]}} & wb_data[i]);
      end
   end

   always_comb begin
      rf_wen_d   = acc && (sel_addr != '0);
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (rf_wen_d) begin
         rf_waddr_d = sel_addr;
         rf_wdata_d = sel_data;
      end
   end

   assign alloc_ready = rst_n & ~busy_q[alloc_rd];
   assign alloc_fire  = alloc_valid & alloc_ready;
   assign rs1_busy    = busy_q[rs1_addr];
   assign rs2_busy    = busy_q[rs2_addr];

   // Clear on commit first so a same-edge allocation of that register wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_wen_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (alloc_fire) begin
         busy_d[alloc_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: reference model + writeback scoreboard,
// a vector table for arbitration, and hand sequences for corner cases.
module tb_rf_wb_arbiter;
   import ysyx_22040000_rf_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NR-1:0]       wb_valid;
   logic [NR-1:0]       wb_ready;
   logic [NR-1:0][AW-1:0] wb_addr;
   logic [NR-1:0][DW-1:0] wb_data;
   logic                rf_wen;
   logic [AW-1:0]       rf_waddr;
   logic [DW-1:0]       rf_wdata;
   logic                alloc_valid;
   logic [AW-1:0]       alloc_rd;
   logic                alloc_ready;
   logic [AW-1:0]       rs1_addr;
   logic [AW-1:0]       rs2_addr;
   logic                rs1_busy;
   logic                rs2_busy;

   always #5 clk = ~clk;

   rf_wb_arbiter #(
      .AWIDTH (AW),
      .DWIDTH (DW),
      .NREQ   (NR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .alloc_ready (alloc_ready),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int n_viol = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] rf_mem [32] = '{default: '0};

   int            m_rr;
   logic [31:0]   m_busy;
   logic          m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   wb_req_t       exp_q [$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic int mgrant();
      int i;
      if (!rst_n) return -1;
      for (int k = 0; k < NR; k++) begin
         i = (m_rr + k) % NR;
         if (wb_valid[i]) return i;
      end
      return -1;
   endfunction

   // Reference model and register-file image, advanced at each edge.
   always @(posedge clk) begin : model
      int g;
      logic [31:0] nb;
      if (!rst_n) begin
         m_rr    <= 0;
         m_busy  <= '0;
         m_wen   <= 1'b0;
         m_waddr <= '0;
         m_wdata <= '0;
         exp_q.delete();
      end else begin
         g  = mgrant();
         nb = m_busy;
         if (m_wen) nb[m_waddr] = 1'b0;
         if (alloc_valid && !m_busy[alloc_rd] && alloc_rd != '0)
            nb[alloc_rd] = 1'b1;
         m_busy <= nb;
         m_wen  <= 1'b0;
         if (g >= 0) begin
            m_rr <= (g + 1) % NR;
            if (wb_addr[g] != '0) begin
               if (!m_busy[wb_addr[g]]) n_viol <= n_viol + 1;
               m_wen   <= 1'b1;
               m_waddr <= wb_addr[g];
               m_wdata <= wb_data[g];
               exp_q.push_back(wb_req_t'{addr: wb_addr[g], data: wb_data[g]});
            end
         end
      end
      if (rst_n && rf_wen) rf_mem[rf_waddr] <= rf_wdata;
   end

   always @(negedge clk) begin : monitor
      int g;
      logic [NR-1:0] er;
      wb_req_t e;
      if (chk_en) begin
         g  = mgrant();
         er = '0;
         if (g >= 0) er[g] = 1'b1;
         chk("mon_wb_ready", wb_ready, er);
         chk("mon_alloc_ready", alloc_ready, rst_n && !m_busy[alloc_rd]);
         chk("mon_rs1_busy", rs1_busy, m_busy[rs1_addr]);
         chk("mon_rs2_busy", rs2_busy, m_busy[rs2_addr]);
         chk("mon_rf_wen", rf_wen, m_wen);
         chk("mon_rf_waddr", rf_waddr, m_waddr);
         chk("mon_rf_wdata", rf_wdata, m_wdata);
         if (rf_wen) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: write x%0d=%0h with empty queue",
                        rf_waddr, rf_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("sb_addr", rf_waddr, e.addr);
               chk("sb_data", rf_wdata, e.data);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]    valid;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [1:0]    ready;
      logic          wen;
      logic [AW-1:0] waddr;
   } vec_t;

   initial begin
      vec_t tbl [9];
      logic [1:0]    cg [4];
      logic [AW-1:0] ca [4];
      logic [DW-1:0] cd [4];

      tbl[0] = '{2'b11, 5'd10, 5'd11, 2'b01, 1'b1, 5'd10};
      tbl[1] = '{2'b11, 5'd12, 5'd11, 2'b10, 1'b1, 5'd11};
      tbl[2] = '{2'b01, 5'd12, 5'd0,  2'b01, 1'b1, 5'd12};
      tbl[3] = '{2'b01, 5'd13, 5'd0,  2'b01, 1'b1, 5'd13};
      tbl[4] = '{2'b00, 5'd0,  5'd0,  2'b00, 1'b0, 5'd13};
      tbl[5] = '{2'b10, 5'd0,  5'd14, 2'b10, 1'b1, 5'd14};
      tbl[6] = '{2'b10, 5'd0,  5'd15, 2'b10, 1'b1, 5'd15};
      tbl[7] = '{2'b11, 5'd16, 5'd17, 2'b01, 1'b1, 5'd16};
      tbl[8] = '{2'b10, 5'd0,  5'd17, 2'b10, 1'b1, 5'd17};
      cg = '{2'b01, 2'b10, 2'b01, 2'b10};
      ca = '{5'd1, 5'd2, 5'd1, 5'd2};
      cd = '{32'h11, 32'h22, 32'h11, 32'h22};

      // Reset with every input asserted.
      rst_n       = 1'b0;
      wb_valid    = '1;
      wb_addr[0]  = 5'd1;
      wb_addr[1]  = 5'd2;
      wb_data[0]  = 32'h1;
      wb_data[1]  = 32'h2;
      alloc_valid = 1'b1;
      alloc_rd    = 5'd5;
      rs1_addr    = 5'd5;
      rs2_addr    = 5'd0;
      tick();
      tick();
      chk_en = 1'b1;
      chk("rst_wb_ready", wb_ready, 2'b00);
      chk("rst_alloc_ready", alloc_ready, 1'b0);
      chk("rst_rf_wen", rf_wen, 1'b0);
      chk("rst_rs1_busy", rs1_busy, 1'b0);

      // Release: both write x0, allocate x0.
      rst_n      = 1'b1;
      wb_addr[0] = 5'd0;
      wb_addr[1] = 5'd0;
      alloc_rd   = 5'd0;
      rs1_addr   = 5'd0;
      #1;
      chk("first_grant", wb_ready, 2'b01);
      chk("alloc_x0_ready", alloc_ready, 1'b1);
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("x0_wen_0", rf_wen, 1'b0);
      chk("second_grant", wb_ready, 2'b10);
      tick();
      wb_valid = '0;
      #1;
      chk("x0_wen_1", rf_wen, 1'b0);
      chk("x0_busy", rs1_busy, 1'b0);

      // Contention between EXU (x1) and LSU (x2).
      alloc_valid = 1'b1;
      alloc_rd    = 5'd1;
      tick();
      alloc_rd = 5'd2;
      tick();
      alloc_valid = 1'b0;
      rs1_addr    = 5'd1;
      rs2_addr    = 5'd2;
      #1;
      chk("cont_busy1", rs1_busy, 1'b1);
      chk("cont_busy2", rs2_busy, 1'b1);
      wb_addr[0] = 5'd1;
      wb_data[0] = 32'h11;
      wb_addr[1] = 5'd2;
      wb_data[1] = 32'h22;
      wb_valid   = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_grant", wb_ready, cg[i]);
         tick();
         chk("cont_wen", rf_wen, 1'b1);
         chk("cont_waddr", rf_waddr, ca[i]);
         chk("cont_wdata", rf_wdata, cd[i]);
      end
      wb_valid = '0;
      tick();

      // Table: allocate x10..x17, then apply arbitration vectors.
      alloc_valid = 1'b1;
      for (int r = 10; r < 18; r++) begin
         alloc_rd = AW'(r);
         #1;
         chk("tbl_alloc_ready", alloc_ready, 1'b1);
         tick();
      end
      alloc_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wb_valid   = tbl[i].valid;
         wb_addr[0] = tbl[i].a0;
         wb_addr[1] = tbl[i].a1;
         wb_data[0] = 32'hC0DE_0000 | 32'(tbl[i].a0);
         wb_data[1] = 32'hC0DE_0000 | 32'(tbl[i].a1);
         #1;
         chk("tbl_ready", wb_ready, tbl[i].ready);
         tick();
         chk("tbl_wen", rf_wen, tbl[i].wen);
         chk("tbl_waddr", rf_waddr, tbl[i].waddr);
         chk("tbl_wdata", rf_wdata, 32'hC0DE_0000 | 32'(tbl[i].waddr));
      end
      wb_valid = '0;
      tick();

      // Allocate x5 and write it back.
      rs1_addr    = 5'd5;
      alloc_valid = 1'b1;
      alloc_rd    = 5'd5;
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("x5_busy_set", rs1_busy, 1'b1);
      wb_valid   = 2'b01;
      wb_addr[0] = 5'd5;
      wb_data[0] = 32'hDEAD_BEEF;
      #1;
      chk("x5_ready", wb_ready, 2'b01);
      tick();
      wb_valid = '0;
      #1;
      chk("x5_wen", rf_wen, 1'b1);
      chk("x5_waddr", rf_waddr, 5'd5);
      chk("x5_wdata", rf_wdata, 32'hDEAD_BEEF);
      chk("x5_busy_hold", rs1_busy, 1'b1);
      tick();
      chk("x5_busy_clr", rs1_busy, 1'b0);
      chk("x5_rf_read", rf_mem[5], 32'hDEAD_BEEF);
      chk("x5_wen_off", rf_wen, 1'b0);

      // WAW stall on x7.
      rs2_addr    = 5'd7;
      alloc_valid = 1'b1;
      alloc_rd    = 5'd7;
      tick();
      #1;
      chk("waw_stall0", alloc_ready, 1'b0);
      chk("waw_busy", rs2_busy, 1'b1);
      wb_valid   = 2'b01;
      wb_addr[0] = 5'd7;
      wb_data[0] = 32'h77;
      #1;
      chk("waw_wb_ready", wb_ready, 2'b01);
      tick();
      wb_valid = '0;
      #1;
      chk("waw_stall1", alloc_ready, 1'b0);
      tick();
      chk("waw_release", alloc_ready, 1'b1);
      chk("waw_rf_read", rf_mem[7], 32'h77);
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("waw_realloc", rs2_busy, 1'b1);
      wb_valid   = 2'b01;
      wb_data[0] = 32'h78;
      tick();
      wb_valid = '0;
      tick();
      chk("waw_drain_busy", rs2_busy, 1'b0);
      chk("waw_drain_rf", rf_mem[7], 32'h78);

      // Reset while a write to x3 is in flight.
      rs1_addr    = 5'd3;
      alloc_valid = 1'b1;
      alloc_rd    = 5'd3;
      tick();
      alloc_valid = 1'b0;
      wb_valid    = 2'b01;
      wb_addr[0]  = 5'd3;
      wb_data[0]  = 32'h3333_3333;
      tick();
      rst_n    = 1'b0;
      wb_valid = 2'b11;
      #1;
      chk("mid_inflight", rf_wen, 1'b1);
      chk("mid_rst_ready", wb_ready, 2'b00);
      tick();
      chk("mid_rf_wen", rf_wen, 1'b0);
      chk("mid_rf_waddr", rf_waddr, 5'd0);
      chk("mid_busy3", rs1_busy, 1'b0);
      tick();
      chk("mid_x3_kept", rf_mem[3], 32'h0);
      rst_n    = 1'b1;
      wb_valid = '0;
      tick();
      tick();

      chk("proto_viol", n_viol, 2);
      chk("sb_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
